// File: rtl/shared_counters_pool.sv
// Pool of N G-bit slices that software groups into variable-width counters.
// Each counter is named by its head slice. Commands arrive on a
// valid/ready handshake. Reads stream out one slice per beat; loads
// take one slice per valid beat, both LS slice first.
module shared_counters_pool #(
    parameter int N  = 16,
    parameter int G  = 4,
    parameter int IW = $clog2(N),
    parameter int SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd,
    input  logic [IW-1:0] cmd_id,
    input  logic [SW-1:0] cmd_size,
    input  logic [G-1:0]  load_data,
    input  logic          load_valid,
    output logic          resp_valid,
    output logic          resp_err,
    output logic [IW-1:0] alloc_id,
    output logic          overflow,
    output logic [G-1:0]  rdata,
    output logic          rdata_valid,
    output logic          rdata_last
);

    typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;

    localparam logic [2:0] CMD_NOP     = 3'b000;
    localparam logic [2:0] CMD_INC     = 3'b001;
    localparam logic [2:0] CMD_ALLOC   = 3'b010;
    localparam logic [2:0] CMD_DEALLOC = 3'b011;
    localparam logic [2:0] CMD_LOAD    = 3'b100;
    localparam logic [2:0] CMD_READ    = 3'b101;

    state_t              state, state_d;
    logic [N-1:0]        free, head;
    logic [N-1:0][G-1:0] slices;
    logic [IW-1:0]       ptr, last_idx;

    logic                accept, id_ok;
    logic [N-1:0]        own;
    logic                own_run;
    logic [IW-1:0]       own_last;
    logic [N-1:0][G-1:0] inc_slices;
    logic                inc_carry;
    int                  size_i, fit_hi;
    logic                fit_ok, fit_found;
    logic [IW-1:0]       fit_h;
    logic [N-1:0]        alloc_mask;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign id_ok     = head[cmd_id];

    // Slices owned by the addressed counter: from its head up to the next head or free slice.
    always_comb begin
        own      = '0;
        own_run  = 1'b0;
        own_last = '0;
        for (int j = 0; j < N; j++) begin
            if (j == int'(cmd_id))
                own_run = 1'b1;
            else if (head[j] || free[j])
                own_run = 1'b0;
            own[j] = own_run;
            if (own_run)
                own_last = IW'(j);
        end
    end

    // Ripple-carry +1 across the owned slices; carry out of the MS slice is the wrap.
    always_comb begin
        inc_slices = slices;
        inc_carry  = 1'b1;
        for (int j = 0; j < N; j++) begin
            if (own[j])
                {inc_carry, inc_slices[j]} = {1'b0, slices[j]} + {{G{1'b0}}, inc_carry};
        end
    end

    // First-fit search for a run of cmd_size free slices.
    always_comb begin
        size_i    = int'(cmd_size);
        fit_found = 1'b0;
        fit_hi    = 0;
        fit_ok    = 1'b0;
        for (int h = 0; h < N; h++) begin
            fit_ok = (size_i != 0) && (h + size_i <= N);
            for (int j = 0; j < N; j++) begin
                if (j >= h && j < h + size_i && !free[j])
                    fit_ok = 1'b0;
            end
            if (fit_ok && !fit_found) begin
                fit_found = 1'b1;
                fit_hi    = h;
            end
        end
        fit_h = IW'(fit_hi);
        for (int j = 0; j < N; j++)
            alloc_mask[j] = fit_found && (j >= fit_hi) && (j < fit_hi + size_i);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Next state: READ/LOAD only for a valid id; leave after the last beat or last slice write.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (accept && id_ok) begin
                    if (cmd == CMD_READ)
                        state_d = READ;
                    else if (cmd == CMD_LOAD)
                        state_d = LOAD;
                end
            end
            READ: begin
                if (rdata_last)
                    state_d = IDLE;
            end
            LOAD: begin
                if (load_valid && ptr == last_idx)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ownership tables, slice data, walk pointer and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free        <= '1;
            head        <= '0;
            slices      <= '0;
            ptr         <= '0;
            last_idx    <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            alloc_id    <= '0;
            overflow    <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            alloc_id    <= '0;
            overflow    <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd)
                            CMD_NOP: ;
                            CMD_INC: begin
                                resp_valid <= 1'b1;
                                if (id_ok) begin
                                    slices   <= inc_slices;
                                    overflow <= inc_carry;
                                end else begin
                                    resp_err <= 1'b1;
                                end
                            end
                            CMD_ALLOC: begin
                                resp_valid <= 1'b1;
                                if (fit_found) begin
                                    alloc_id     <= fit_h;
                                    head[fit_h]  <= 1'b1;
                                    free         <= free & ~alloc_mask;
                                    for (int j = 0; j < N; j++)
                                        if (alloc_mask[j])
                                            slices[j] <= '0;
                                end else begin
                                    resp_err <= 1'b1;
                                end
                            end
                            CMD_DEALLOC: begin
                                resp_valid <= 1'b1;
                                if (id_ok) begin
                                    free         <= free | own;
                                    head[cmd_id] <= 1'b0;
                                end else begin
                                    resp_err <= 1'b1;
                                end
                            end
                            CMD_LOAD: begin
                                if (id_ok) begin
                                    ptr      <= cmd_id;
                                    last_idx <= own_last;
                                end else begin
                                    resp_valid <= 1'b1;
                                    resp_err   <= 1'b1;
                                end
                            end
                            CMD_READ: begin
                                if (id_ok) begin
                                    rdata       <= slices[cmd_id];
                                    rdata_valid <= 1'b1;
                                    rdata_last  <= (cmd_id == own_last);
                                    ptr         <= cmd_id + 1'b1;
                                    last_idx    <= own_last;
                                end else begin
                                    resp_valid <= 1'b1;
                                    resp_err   <= 1'b1;
                                end
                            end
                            default: begin
                                resp_valid <= 1'b1;
                                resp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                READ: begin
                    if (!rdata_last) begin
                        rdata       <= slices[ptr];
                        rdata_valid <= 1'b1;
                        rdata_last  <= (ptr == last_idx);
                        ptr         <= ptr + 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid) begin
                        slices[ptr] <= load_data;
                        if (ptr == last_idx)
                            resp_valid <= 1'b1;
                        else
                            ptr <= ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_counters_pool.sv
// Bench for shared_counters_pool (N=8, G=4): transaction-level model with a
// per-cycle output compare, plus directed scenarios with literal expectations.
module tb_shared_counters_pool;

    localparam int N  = 8;
    localparam int G  = 4;
    localparam int IW = 3;
    localparam int SW = 4;

    localparam logic [2:0] C_INC = 3'b001, C_ALLOC = 3'b010, C_DEALLOC = 3'b011;
    localparam logic [2:0] C_LOAD = 3'b100, C_READ = 3'b101, C_RSVD = 3'b110;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd = '0;
    logic [IW-1:0] cmd_id = '0;
    logic [SW-1:0] cmd_size = '0;
    logic [G-1:0]  load_data = '0;
    logic          load_valid = 1'b0;
    logic          resp_valid, resp_err, overflow, rdata_valid, rdata_last;
    logic [IW-1:0] alloc_id;
    logic [G-1:0]  rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    shared_counters_pool #(.N(N), .G(G), .IW(IW), .SW(SW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_id(cmd_id), .cmd_size(cmd_size),
        .load_data(load_data), .load_valid(load_valid),
        .resp_valid(resp_valid), .resp_err(resp_err), .alloc_id(alloc_id),
        .overflow(overflow), .rdata(rdata), .rdata_valid(rdata_valid),
        .rdata_last(rdata_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_free [N];
    logic          m_head [N];
    logic [G-1:0]  m_slice[N];
    int            m_mode;          // 0 idle, 1 streaming read beats, 2 collecting load beats
    logic [G-1:0]  rd_q[$];
    int            ld_q[$];
    int            m_own[$];
    logic          e_rv, e_err, e_ovf, e_dv, e_last;
    logic [IW-1:0] e_aid;
    logic [G-1:0]  e_dat;

    task automatic find_own(input int h);
        m_own.delete();
        m_own.push_back(h);
        for (int j = h + 1; j < N; j++) begin
            if (m_head[j] || m_free[j]) break;
            m_own.push_back(j);
        end
    endtask

    task automatic model_cmd();
        longint v, full;
        int n, s, h;
        logic ok;
        if (cmd == 3'b000) return;
        if (cmd == C_ALLOC) begin
            e_rv = 1'b1;
            s = int'(cmd_size);
            h = -1;
            if (s != 0 && s <= N) begin
                for (int c = 0; c + s <= N && h < 0; c++) begin
                    ok = 1'b1;
                    for (int k = c; k < c + s; k++) if (!m_free[k]) ok = 1'b0;
                    if (ok) h = c;
                end
            end
            if (h < 0) e_err = 1'b1;
            else begin
                e_aid = IW'(h);
                m_head[h] = 1'b1;
                for (int k = h; k < h + s; k++) begin m_free[k] = 1'b0; m_slice[k] = '0; end
            end
            return;
        end
        if (cmd > C_READ || !m_head[cmd_id]) begin
            e_rv = 1'b1; e_err = 1'b1;
            return;
        end
        find_own(int'(cmd_id));
        n = m_own.size();
        case (cmd)
            C_INC: begin
                e_rv = 1'b1;
                v = 0;
                for (int i = n - 1; i >= 0; i--) v = (v << G) | longint'(m_slice[m_own[i]]);
                full = (longint'(1) << (n * G)) - 1;
                if (v == full) begin v = 0; e_ovf = 1'b1; end
                else v = v + 1;
                for (int i = 0; i < n; i++) m_slice[m_own[i]] = G'(v >> (i * G));
            end
            C_DEALLOC: begin
                e_rv = 1'b1;
                foreach (m_own[i]) m_free[m_own[i]] = 1'b1;
                m_head[cmd_id] = 1'b0;
            end
            C_LOAD: begin
                ld_q = m_own;
                m_mode = 2;
            end
            default: begin
                rd_q.delete();
                foreach (m_own[i]) rd_q.push_back(m_slice[m_own[i]]);
                e_dv = 1'b1; e_dat = rd_q.pop_front(); e_last = (rd_q.size() == 0);
                m_mode = 1;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_free[i] = 1'b1; m_head[i] = 1'b0; m_slice[i] = '0; end
            m_mode = 0; rd_q.delete(); ld_q.delete();
            e_rv = 0; e_err = 0; e_ovf = 0; e_dv = 0; e_last = 0; e_aid = '0; e_dat = '0;
        end else begin
            e_rv = 0; e_err = 0; e_ovf = 0; e_dv = 0; e_last = 0; e_aid = '0; e_dat = '0;
            if (m_mode == 1) begin
                if (rd_q.size() > 0) begin
                    e_dv = 1'b1; e_dat = rd_q.pop_front(); e_last = (rd_q.size() == 0);
                end else m_mode = 0;
            end else if (m_mode == 2) begin
                if (load_valid) begin
                    m_slice[ld_q.pop_front()] = load_data;
                    if (ld_q.size() == 0) begin e_rv = 1'b1; m_mode = 0; end
                end
            end else if (cmd_valid) begin
                model_cmd();
            end
        end
    end

    // Per-cycle compare of every output against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, m_mode == 0);
            chk("resp_valid", resp_valid, e_rv);
            chk("resp_err", resp_err, e_err);
            chk("alloc_id", alloc_id, e_aid);
            chk("overflow", overflow, e_ovf);
            chk("rdata_valid", rdata_valid, e_dv);
            chk("rdata_last", rdata_last, e_last);
            if (e_dv) chk("rdata", rdata, e_dat);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [2:0] c, input int id, input int sz);
        cmd_valid = 1'b1; cmd = c; cmd_id = id[IW-1:0]; cmd_size = sz[SW-1:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd = '0; cmd_id = '0; cmd_size = '0;
    endtask

    task automatic resp_lit(input string nm, input int err, input int aid, input int ovf);
        @(negedge clk);
        chk({nm, "_valid"}, resp_valid, 1);
        chk({nm, "_err"}, resp_err, err);
        chk({nm, "_id"}, alloc_id, aid);
        chk({nm, "_ovf"}, overflow, ovf);
        @(posedge clk); #1;
    endtask

    task automatic do_load(input int id, input logic [31:0] val, input logic [7:0] pat, input int plen);
        int k;
        send(C_LOAD, id, 0);
        k = 0;
        for (int i = 0; i < plen; i++) begin
            load_valid = pat[i];
            load_data  = val[k*G +: G];
            @(negedge clk);
            chk("load_busy", cmd_ready, 0);
            @(posedge clk); #1;
            if (pat[i]) k++;
        end
        load_valid = 1'b0;
        resp_lit("load", 0, 0, 0);
    endtask

    task automatic read_expect(input int id, input int n, input logic [31:0] val);
        int got;
        logic done;
        send(C_READ, id, 0);
        got = 0; done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (rdata_valid) begin
                chk("read_beat", rdata, val[got*G +: G]);
                chk("read_last", rdata_last, got == n - 1);
                got++;
                if (rdata_last) done = 1'b1;
            end
        end
        chk("read_beats", got, n);
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b1;
        #3 chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_resp", resp_valid, 0);
        chk("rst_rvalid", rdata_valid, 0);
        rst = 1'b0;

        send(C_ALLOC, 0, 3); resp_lit("alloc3", 0, 0, 0);
        send(C_ALLOC, 0, 2); resp_lit("alloc2", 0, 3, 0);
        send(C_ALLOC, 0, 4); resp_lit("alloc4_full", 1, 0, 0);

        do_load(0, 32'h0FF, 8'b111, 3);
        send(C_INC, 0, 0); resp_lit("inc0", 0, 0, 0);
        read_expect(0, 3, 32'h100);

        do_load(3, 32'hFF, 8'b11, 2);
        send(C_INC, 3, 0); resp_lit("inc3_wrap", 0, 0, 1);
        read_expect(3, 2, 32'h00);
        read_expect(0, 3, 32'h100);

        send(C_DEALLOC, 0, 0); resp_lit("dealloc0", 0, 0, 0);
        send(C_ALLOC, 0, 2); resp_lit("realloc2", 0, 0, 0);
        send(C_INC, 1, 0); resp_lit("inc_badid", 1, 0, 0);

        do_load(0, 32'h5A, 8'b1001, 4);
        read_expect(0, 2, 32'h5A);

        send(C_ALLOC, 0, 1); resp_lit("alloc1", 0, 2, 0);
        read_expect(2, 1, 32'h0);
        send(C_ALLOC, 0, 9); resp_lit("alloc_big", 1, 0, 0);
        send(C_ALLOC, 0, 0); resp_lit("alloc_zero", 1, 0, 0);
        send(C_RSVD, 0, 0); resp_lit("reserved", 1, 0, 0);
        send(C_READ, 5, 0); resp_lit("read_badid", 1, 0, 0);

        do_load(3, 32'h3C, 8'b11, 2);
        send(C_READ, 3, 0);
        @(negedge clk);
        chk("beat1_valid", rdata_valid, 1);
        chk("beat1_data", rdata, 4'hC);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("abort_rvalid", rdata_valid, 0);
        chk("abort_ready", cmd_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);
        @(posedge clk); #1;
        send(C_ALLOC, 0, 8); resp_lit("alloc_all", 0, 0, 0);
        read_expect(0, 8, 32'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
